// File: rtl/opcode_sequencer.sv
// opcode_sequencer
//   Expands queued 8-bit macro opcodes into sequences of 32-bit CPU
//   instructions and hands them to the CPU one at a time over a
//   valid/accept handshake.
//
// Ports
//   Clk      in   rising-edge clock
//   Rst      in   synchronous active-high reset
//   Opcode   in   [7:0] macro opcode
//   Rd/Rs/Rt in   [4:0] register operands, captured at enqueue
//   Start    in   enqueue {Opcode,Rd,Rs,Rt} when Ready=1
//   Accept   in   CPU consumes CPUIns this cycle
//   Ready    out  queue not full and not halted (combinational)
//   GiveIns  out  CPUIns valid
//   CPUIns   out  [31:0] current instruction, 0 when GiveIns=0
//   Illegal  out  one-cycle pulse when an undefined opcode is dropped
//   Halted   out  sticky halt, cleared only by Rst
//   Busy     out  FSM not idle or queue non-empty
module opcode_sequencer #(
    parameter int           QDEPTH = 4,
    parameter int           MAXSEQ = 4,
    parameter logic [4:0]   SCR    = 5'h11,
    parameter logic [4:0]   LINK   = 5'h1F
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  Opcode,
    input  logic [4:0]  Rd,
    input  logic [4:0]  Rs,
    input  logic [4:0]  Rt,
    input  logic        Start,
    input  logic        Accept,
    output logic        Ready,
    output logic        GiveIns,
    output logic [31:0] CPUIns,
    output logic        Illegal,
    output logic        Halted,
    output logic        Busy
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int IW = $clog2(MAXSEQ);
    localparam int LW = $clog2(MAXSEQ + 1);
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    typedef struct packed {
        logic [7:0] op;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE} state_t;

    // ------------------------------------------------------------------
    // Opcode queue (circular buffer)
    // ------------------------------------------------------------------
    entry_t          q_mem_q [QDEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    logic            push, pop;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready uses the pre-edge count: a full queue refuses Start even if a
    // pop happens in the same cycle.
    assign push = Start && Ready;

    always_ff @(posedge Clk) begin
        if (push) q_mem_q[tail_q] <= '{op: Opcode, rd: Rd, rs: Rs, rt: Rt};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= ptr_nxt(tail_q);
            if (pop)  head_q <= ptr_nxt(head_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Decoder: head entry -> instruction slots and sequence length
    // ------------------------------------------------------------------
    entry_t                   hd;
    logic [MAXSEQ-1:0][31:0]  dec_slot;
    logic [LW-1:0]            dec_len;
    logic                     dec_halt;

    function automatic logic [31:0] r3(input logic [5:0] fn, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] c);
        return {fn, a, b, c, 11'h0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] fn, input logic [4:0] a,
                                       input logic [4:0] b, input logic [15:0] imm);
        return {fn, a, b, imm};
    endfunction

    // ALU function codes for opcodes 0x00-0x0A (irregular spacing)
    function automatic logic [5:0] fn_lo(input logic [3:0] o);
        case (o)
            4'h0:    return 6'h01;
            4'h1:    return 6'h02;
            4'h2:    return 6'h05;
            4'h3:    return 6'h06;
            4'h4:    return 6'h09;
            4'h5:    return 6'h0A;
            4'h6:    return 6'h0D;
            4'h7:    return 6'h0E;
            4'h8:    return 6'h11;
            4'h9:    return 6'h13;
            default: return 6'h15;
        endcase
    endfunction

    assign hd = q_mem_q[head_q];

    always_comb begin
        dec_slot = '0;
        dec_len  = '0;
        dec_halt = 1'b0;
        if (hd.op <= 8'h0A) begin
            dec_slot[0] = r3(fn_lo(hd.op[3:0]), hd.rd, hd.rs, hd.rt);
            dec_len     = LW'(1);
        end else if (hd.op == 8'h0B) begin
            dec_slot[0] = ri(6'h17, hd.rd, hd.rs, 16'h0);
            dec_len     = LW'(1);
        end else if (hd.op <= 8'h0F) begin
            dec_slot[0] = r3(6'h18 + {4'h0, hd.op[1:0]}, hd.rd, hd.rs, hd.rt);
            dec_len     = LW'(1);
        end else if (hd.op <= 8'h15) begin
            dec_slot[0] = r3(6'h22 + {2'h0, hd.op[3:0]}, hd.rd, hd.rs, hd.rt);
            dec_len     = LW'(1);
        end else if (hd.op == 8'h16) begin
            // load then increment the destination in place
            dec_slot[0] = ri(6'h17, hd.rd, hd.rs, 16'h0);
            dec_slot[1] = ri(6'h03, hd.rd, hd.rd, 16'h1);
            dec_len     = LW'(2);
        end else if (hd.op <= 8'h19) begin
            dec_slot[0] = ri(6'h01, hd.rd, hd.rs, 16'h0);
            dec_len     = LW'(1);
        end else if (hd.op == 8'h40) begin
            dec_slot[0] = ri(6'h28, hd.rs, hd.rt, 16'h0);
            dec_len     = LW'(1);
        end else if (hd.op >= 8'h41 && hd.op <= 8'h46) begin
            // compute into scratch, then store scratch through Rd
            dec_slot[0] = r3(6'h22 + {3'h0, 3'(hd.op[2:0] - 3'd1)}, SCR, hd.rs, hd.rt);
            dec_slot[1] = ri(6'h28, SCR, hd.rd, 16'h0);
            dec_len     = LW'(2);
        end else if (hd.op == 8'h47) begin
            dec_slot[0] = ri(6'h29, 5'h0, hd.rs, 16'h0);
            dec_len     = LW'(1);
        end else if (hd.op == 8'h49) begin
            dec_slot[0] = ri(6'h2B, 5'h0, hd.rs, 16'h0);
            dec_len     = LW'(1);
        end else if (hd.op == 8'h4A) begin
            // swap Rs and Rt through the scratch register
            dec_slot[0] = r3(6'h01, SCR, hd.rs, 5'h0);
            dec_slot[1] = r3(6'h01, hd.rs, hd.rt, 5'h0);
            dec_slot[2] = r3(6'h01, hd.rt, SCR, 5'h0);
            dec_len     = LW'(3);
        end else if (hd.op == 8'h80) begin
            dec_slot[0] = {6'h2A, LINK, 21'h0};
            dec_len     = LW'(1);
        end else if (hd.op == 8'h81) begin
            dec_slot[0] = {6'h3F, 26'h0};
            dec_len     = LW'(1);
            dec_halt    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t                   state_q, state_d;
    logic [MAXSEQ-1:0][31:0]  slot_q, slot_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [IW-1:0]            last_q, last_d;
    logic                     halt_seq_q, halt_seq_d;
    logic                     halted_q, halted_d;
    logic                     illegal_q, illegal_d;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            halt_seq_q <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            halt_seq_q <= halt_seq_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        idx_d      = idx_q;
        last_d     = last_q;
        halt_seq_d = halt_seq_q;
        halted_d   = halted_q;
        illegal_d  = 1'b0;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0 && !halted_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    slot_d     = dec_slot;
                    idx_d      = '0;
                    last_d     = IW'(dec_len - 1'b1);
                    halt_seq_d = dec_halt;
                    if (dec_len == '0) begin
                        // drop it; go straight on to the next entry if any
                        illegal_d = 1'b1;
                        state_d   = (count_q > CW'(1)) ? S_LOAD : S_IDLE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (Accept) begin
                    if (idx_q != last_q) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        if (halt_seq_q) halted_d = 1'b1;
                        state_d = (count_q != '0 && !halt_seq_q) ? S_LOAD : S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Ready   = (count_q != QFULL) && !halted_q;
    assign GiveIns = (state_q == S_ISSUE);
    assign CPUIns  = GiveIns ? slot_q[idx_q] : 32'h0;
    assign Illegal = illegal_q;
    assign Halted  = halted_q;
    assign Busy    = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_opcode_sequencer.sv
module tb_opcode_sequencer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  Opcode;
    logic [4:0]  Rd, Rs, Rt;
    logic        Start, Accept;
    logic        Ready, GiveIns, Illegal, Halted, Busy;
    logic [31:0] CPUIns;

    opcode_sequencer dut (
        .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Rd(Rd), .Rs(Rs), .Rt(Rt),
        .Start(Start), .Accept(Accept), .Ready(Ready), .GiveIns(GiveIns),
        .CPUIns(CPUIns), .Illegal(Illegal), .Halted(Halted), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int          nchk = 0;
    int          nerr = 0;
    int          ill_cnt = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Outputs are sampled 1 time unit after the previous
    // edge; any valid instruction is checked against the scoreboard head,
    // and popped only when the CPU accepts it.
    task automatic tick();
        if (GiveIns === 1'b1) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $error("FAIL sb_extra observed=%h expected=none", CPUIns);
            end else begin
                chk("ins", CPUIns, exp_q[0]);
                if (Accept) void'(exp_q.pop_front());
            end
        end else begin
            chk("ins_zero", CPUIns, 32'h0);
        end
        if (Illegal === 1'b1) ill_cnt++;
        @(posedge Clk);
        #1;
    endtask

    task automatic drain(input int max, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_give(input int max);
        int n = 0;
        while (GiveIns !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("wait_give", GiveIns, 1'b1);
    endtask

    task automatic enq(input logic [7:0] op, input logic [4:0] d, input logic [4:0] s,
                       input logic [4:0] t);
        Opcode = op; Rd = d; Rs = s; Rt = t; Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [0:5] rdy_tbl;
        Rst = 1'b1; Opcode = '0; Rd = '0; Rs = '0; Rt = '0; Start = 1'b0; Accept = 1'b0;
        @(posedge Clk); #1;
        do_reset();

        // reset state
        chk("rst_ready",   Ready,   1'b1);
        chk("rst_give",    GiveIns, 1'b0);
        chk("rst_cpuins",  CPUIns,  32'h0);
        chk("rst_illegal", Illegal, 1'b0);
        chk("rst_halted",  Halted,  1'b0);
        chk("rst_busy",    Busy,    1'b0);

        // single opcode, latency of two edges after Start
        Accept = 1'b1;
        exp_q.push_back(32'h88642800);
        enq(8'h10, 5'd3, 5'd4, 5'd5);
        chk("lat_t0_give", GiveIns, 1'b0);
        chk("lat_t0_busy", Busy,    1'b1);
        tick();
        chk("lat_t1_give", GiveIns, 1'b0);
        tick();
        chk("lat_t2_give", GiveIns, 1'b1);
        chk("lat_t2_ins",  CPUIns,  32'h88642800);
        tick();
        chk("lat_t3_give", GiveIns, 1'b0);
        chk("lat_t3_sb",   exp_q.size(), 0);

        // swap with stall; operand inputs change after enqueue
        Accept = 1'b0;
        exp_q.push_back(32'h06220000);
        exp_q.push_back(32'h04470000);
        exp_q.push_back(32'h04F10000);
        enq(8'h4A, 5'd9, 5'd2, 5'd7);
        Rs = 5'd30; Rt = 5'd29;
        tick(); tick();
        chk("stall0_ins", CPUIns, 32'h06220000);
        tick();
        chk("stall1_ins", CPUIns, 32'h06220000);
        tick();
        Accept = 1'b1;
        drain(10, n);
        tick();

        // back-to-back 0x41, 0x00, 0x4A; one bubble between opcodes
        exp_q.push_back(32'h8A221800);
        exp_q.push_back(32'hA2210000);
        exp_q.push_back(32'h04853000);
        exp_q.push_back(32'h06280000);
        exp_q.push_back(32'h05090000);
        exp_q.push_back(32'h05310000);
        Opcode = 8'h41; Rd = 5'd1; Rs = 5'd2; Rt = 5'd3; Start = 1'b1; tick();
        Opcode = 8'h00; Rd = 5'd4; Rs = 5'd5; Rt = 5'd6; tick();
        Opcode = 8'h4A; Rd = 5'd0; Rs = 5'd8; Rt = 5'd9; tick();
        Start = 1'b0;
        chk("b2b_first_give", GiveIns, 1'b1);
        drain(20, n);
        chk("b2b_cycles", n, 8);
        tick(); tick();
        chk("b2b_idle_busy", Busy, 1'b0);

        // queue fill with CPU stalled: Ready low only when QDEPTH pending
        Accept = 1'b0;
        rdy_tbl = 6'b111100;
        for (int i = 0; i < 5; i++) exp_q.push_back({6'h01, 5'(i), 21'h0});
        Opcode = 8'h00; Rs = 5'd0; Rt = 5'd0; Start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            Rd = 5'(i);
            tick();
            chk($sformatf("fill_ready%0d", i), Ready, rdy_tbl[i]);
        end
        Start = 1'b0;
        Accept = 1'b1;
        drain(30, n);
        tick(); tick();
        chk("fill_ready_after", Ready, 1'b1);
        chk("fill_busy_after",  Busy,  1'b0);

        // illegal opcode then a legal one
        ill_cnt = 0;
        exp_q.push_back(32'h04432000);
        enq(8'h48, 5'd1, 5'd1, 5'd1);
        enq(8'h00, 5'd2, 5'd3, 5'd4);
        drain(20, n);
        tick(); tick();
        chk("illegal_pulses", ill_cnt, 1);

        // halt: 0x00 behind 0x81 never issues
        exp_q.push_back(32'hFC000000);
        enq(8'h81, 5'd0, 5'd0, 5'd0);
        enq(8'h00, 5'd7, 5'd7, 5'd7);
        drain(20, n);
        chk("halt_halted", Halted, 1'b1);
        chk("halt_ready",  Ready,  1'b0);
        for (int i = 0; i < 6; i++) tick();
        enq(8'h10, 5'd1, 5'd1, 5'd1);
        tick(); tick(); tick();
        chk("halt_give",   GiveIns, 1'b0);
        chk("halt_busy",   Busy,    1'b1);
        chk("halt_sticky", Halted,  1'b1);
        do_reset();
        chk("halt_rst_ready",  Ready,  1'b1);
        chk("halt_rst_halted", Halted, 1'b0);
        chk("halt_rst_busy",   Busy,   1'b0);

        // reset in the middle of a sequence
        exp_q.push_back(32'h06220000);
        enq(8'h4A, 5'd0, 5'd2, 5'd7);
        wait_give(10);
        tick();
        chk("mid_second_ins", CPUIns, 32'h04470000);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        chk("mid_rst_give",   GiveIns, 1'b0);
        chk("mid_rst_cpuins", CPUIns,  32'h0);
        chk("mid_rst_busy",   Busy,    1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("mid_rst_sb", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/opcode_sequencer.md
Name: opcode_sequencer

Overview:
- Parametrised successor to the single-opcode expander: translates 8-bit macro opcodes into sequences of 32-bit CPU instructions.
- Adds a queued opcode input (QDEPTH entries) and caller-supplied register operands (Rd/Rs/Rt) in place of fixed register numbers.
- Adds a per-instruction valid/accept handshake toward the CPU, an illegal-opcode flag, and a sticky halt.
- Sits between the opcode source (loader/ROM) and the CPU instruction input.

Parameters:
- QDEPTH, 4: opcode queue entries; must be >= 1.
- MAXSEQ, 4: instruction slots per opcode; must be >= 3.
- SCR, 5'h11: scratch register number used by multi-step opcodes.
- LINK, 5'h1F: link register number used by opcode 0x80.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous, active-high reset
- Opcode  in  8  macro opcode
- Rd  in  5  destination register operand
- Rs  in  5  source operand 1
- Rt  in  5  source operand 2
- Start  in  1  enqueue {Opcode,Rd,Rs,Rt} when Ready=1
- Accept  in  1  CPU consumes CPUIns this cycle
- Ready  out  1  queue not full and not halted (combinational)
- GiveIns  out  1  CPUIns valid
- CPUIns  out  32  current instruction; 0 when GiveIns=0
- Illegal  out  1  one-cycle pulse, undefined opcode dropped
- Halted  out  1  sticky halt
- Busy  out  1  FSM not IDLE or queue non-empty

Behaviour:
- Reset (Rst=1 at an edge) dominates all other inputs, including mid-sequence:
  - queue flushed, FSM=IDLE, slot index=0;
  - GiveIns=0, CPUIns=0, Illegal=0, Halted=0, Busy=0, Ready=1 (the cycle after).
- Enqueue:
  - Start=1 and Ready=1 at an edge writes the entry.
  - Start while Ready=0 is ignored; no error is raised.
  - Start and a pop at the same edge are both legal. Ready is based on the pre-edge count, so a full queue rejects Start even when a pop occurs in that cycle.
- FSM states: IDLE, LOAD, ISSUE.
  - IDLE -> LOAD when the queue is non-empty and Halted=0.
  - LOAD: pop the head, decode into slot registers, set length L and idx=0.
    - L=0 (illegal opcode): pulse Illegal, next state LOAD if the queue is non-empty, else IDLE.
    - L>0: next state ISSUE.
  - ISSUE: GiveIns=1, CPUIns=slot[idx].
    - Accept=0: hold the output unchanged.
    - Accept=1 and idx<L-1: idx+1.
    - Accept=1 and idx=L-1: next state LOAD if the queue is non-empty and not halted, else IDLE.
- Latency: Start at edge t into an empty, idle block gives LOAD after t, GiveIns=1 after edge t+2.
- Back-to-back throughput: one instruction per cycle within a sequence. One LOAD bubble between opcodes.
- Accept while GiveIns=0 is ignored.
- Instruction field order: fn[31:26], A[25:21], B[20:16], then C[15:11]+11'h0 or imm[15:0].
- Decode table (unlisted opcodes are illegal):
  - 0x00-0x15, one instruction {fn,Rd,Rs,Rt,11'h0}, with fn:
    - 0x00-0x0A -> 01,02,05,06,09,0A,0D,0E,11,13,15
    - 0x0B -> 17, with imm=0 in place of Rt
    - 0x0C-0x0F -> 18,19,1A,1B
    - 0x10-0x15 -> 22-27
  - 0x16, two instructions: {17,Rd,Rs,16'h0}, then {03,Rd,Rd,16'h1}.
  - 0x17-0x19, one instruction: {01,Rd,Rs,16'h0}.
  - 0x40, one instruction: {28,Rs,Rt,16'h0}.
  - 0x41-0x46, two instructions: {22..27,SCR,Rs,Rt,11'h0}, then {28,SCR,Rd,16'h0}.
  - 0x47: {29,0,Rs,16'h0}.
  - 0x49: {2B,0,Rs,16'h0}.
  - 0x4A, three instructions: {01,SCR,Rs,0,11'h0}, {01,Rs,Rt,0,11'h0}, {01,Rt,SCR,0,11'h0}.
  - 0x80: {2A,LINK,21'h0}.
  - 0x81: {3F,26'h0}.
- Halt: the edge that accepts the 0x81 instruction sets Halted=1.
  - FSM goes to IDLE and Ready=0.
  - Queued entries are retained but not issued.
  - Only Rst clears Halted.
- Operands are captured at enqueue; later changes on Rd/Rs/Rt do not affect queued or in-flight sequences.

Test Plan:
- Reset, then Start with Opcode=0x10, Rd=3, Rs=4, Rt=5, Accept=1 -> GiveIns=1 two cycles after the Start edge, CPUIns=32'h88642800 for 1 cycle, then GiveIns=0.
- Opcode=0x4A, Rs=2, Rt=7, with Accept low for the first 2 ISSUE cycles -> CPUIns holds 32'h06220000 while stalled. Then 32'h04470000, then 32'h04F10000, one per accepted cycle.
- Enqueue 0x41, 0x00, 0x4A back-to-back with Accept=1 -> 6 instructions in order, one LOAD bubble between opcodes. With Start held, Ready drops only when QDEPTH entries are pending.
- Opcode=0x48 -> Illegal pulses exactly 1 cycle, GiveIns stays 0, the following queued opcode issues normally.
- Enqueue 0x81 then 0x00 -> 32'hFC000000 issued, Halted=1 after Accept, Ready=0, opcode 0x00 never issued. Rst then restores Ready=1, Halted=0.
- Assert Rst during the second instruction of 0x4A -> next cycle GiveIns=0, CPUIns=0, Busy=0. Remaining instructions are never issued.
